fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 4-bit CPU.
- Owns the program counter and drives the address of the combinational instruction ROM (16 x 8-bit).
- Registers the fetched byte and hands it to the execute stage over a valid/ready handshake.
- Applies jumps, and supports run, single-step and halt control from the top level or debug logic.

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/program_counter.sv | 39 +++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encoding
// and the NOP instruction word presented while nothing has been fetched.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_ISSUE = 2'd2
   } fetch_state_e;

   localparam logic [7:0] INSTR_NOP = 8'h00;

endpackage

// File: rtl/program_counter.sv
// Loadable wrap-around counter used as the CPU program counter.
// A load has priority over an increment; the increment wraps modulo 2^W.
module program_counter #(
   parameter int             W         = 4,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RESET_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational ROM
// and hands each instruction to execute over a valid/ready handshake.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                ADRS_W   = 4,
   parameter int                DATA_W   = 8,
   parameter logic [ADRS_W-1:0] RESET_PC = '0
) (
   input  logic              clk_cpu,
   input  logic              reset,
   output logic [ADRS_W-1:0] rom_adrs,
   input  logic [DATA_W-1:0] rom_dat,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jmp_en,
   input  logic [ADRS_W-1:0] jmp_adrs,
   input  logic              run,
   input  logic              step,
   input  logic              halt_req,
   output logic [ADRS_W-1:0] pc,
   output logic              halted
);

   fetch_state_e      state_q;
   logic [DATA_W-1:0] instr_q;
   logic              instr_valid_q;
   logic              halted_q;
   logic              step_mode_q;

   logic              handshake;
   logic              pc_load;
   logic              pc_inc;
   logic [ADRS_W-1:0] pc_cur;

   // Jumps and increments only ever happen on the cycle the instruction is taken.
   assign handshake = (state_q == FS_ISSUE) & instr_valid_q & instr_ready;
   assign pc_load   = handshake & jmp_en;
   assign pc_inc    = handshake & ~jmp_en;

   program_counter #(
      .W         (ADRS_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk        (clk_cpu),
      .rst_n      (reset),
      .load_i     (pc_load),
      .load_val_i (jmp_adrs),
      .inc_i      (pc_inc),
      .cnt_o      (pc_cur)
   );

   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         state_q       <= FS_IDLE;
         instr_q       <= DATA_W'(INSTR_NOP);
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b1;
         step_mode_q   <= 1'b0;
      end else begin
         case (state_q)
            FS_IDLE: begin
               instr_valid_q <= 1'b0;
               halted_q      <= 1'b1;
               // run has priority over step, so a simultaneous step starts free-running.
               if (run || step) begin
                  state_q     <= FS_FETCH;
                  step_mode_q <= ~run;
                  halted_q    <= 1'b0;
               end
            end
            FS_FETCH: begin
               instr_q       <= rom_dat;
               instr_valid_q <= 1'b1;
               halted_q      <= 1'b0;
               state_q       <= FS_ISSUE;
            end
            FS_ISSUE: begin
               if (handshake) begin
                  instr_valid_q <= 1'b0;
                  if (halt_req || step_mode_q || !run) begin
                     state_q  <= FS_IDLE;
                     halted_q <= 1'b1;
                  end else begin
                     state_q  <= FS_FETCH;
                  end
               end
            end
            default: begin
               state_q       <= FS_IDLE;
               instr_valid_q <= 1'b0;
               halted_q      <= 1'b1;
            end
         endcase
      end
   end

   assign rom_adrs    = pc_cur;
   assign pc          = pc_cur;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand sequences
// for wrap/backpressure/async reset, and random stimulus against a model.
module tb_fetch_ctrl;

   logic       clk_cpu = 1'b0;
   logic       reset   = 1'b0;
   logic [3:0] rom_adrs, pc, jmp_adrs;
   logic [7:0] rom_dat, instr;
   logic       instr_valid, instr_ready, jmp_en, run, step, halt_req, halted;

   logic [7:0] rom_mem [16];
   assign rom_dat = rom_mem[rom_adrs];

   always #5 clk_cpu = ~clk_cpu;

   fetch_ctrl #(
      .ADRS_W   (4),
      .DATA_W   (8),
      .RESET_PC (4'h0)
   ) dut (
      .clk_cpu     (clk_cpu),
      .reset       (reset),
      .rom_adrs    (rom_adrs),
      .rom_dat     (rom_dat),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jmp_en      (jmp_en),
      .jmp_adrs    (jmp_adrs),
      .run         (run),
      .step        (step),
      .halt_req    (halt_req),
      .pc          (pc),
      .halted      (halted)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic v, input logic [7:0] i,
                             input logic [3:0] p, input logic h);
      check({tag, ".valid"},  32'(instr_valid), 32'(v));
      check({tag, ".instr"},  32'(instr),       32'(i));
      check({tag, ".pc"},     32'(pc),          32'(p));
      check({tag, ".adrs"},   32'(rom_adrs),    32'(p));
      check({tag, ".halted"}, 32'(halted),      32'(h));
   endtask

   task automatic tick;
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic rdy, input logic j,
                        input logic [3:0] ja, input logic hr);
      run = r; step = s; instr_ready = rdy; jmp_en = j; jmp_adrs = ja; halt_req = hr;
   endtask

   task automatic do_reset;
      drive(0, 0, 0, 0, 4'h0, 0);
      @(negedge clk_cpu);
      reset = 1'b0;
      #2;
      check_outs("rst_hold", 1'b0, 8'h00, 4'h0, 1'b1);
      @(negedge clk_cpu);
      reset = 1'b1;
   endtask

   task automatic load_rom_seq;
      for (int i = 0; i < 16; i++) rom_mem[i] = 8'h10 + 8'(i);
   endtask

   // Directed vectors: inputs held over one edge, outputs expected right after it.
   typedef struct {
      logic       run, step, ready, jmp;
      logic [3:0] jadr;
      logic       halt;
      logic       ev;
      logic [7:0] ei;
      logic [3:0] ep;
      logic       eh;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic s, input logic rdy, input logic j,
                               input logic [3:0] ja, input logic hr, input logic ev,
                               input logic [7:0] ei, input logic [3:0] ep, input logic eh);
      vec_t v;
      v.run = r; v.step = s; v.ready = rdy; v.jmp = j; v.jadr = ja; v.halt = hr;
      v.ev = ev; v.ei = ei; v.ep = ep; v.eh = eh;
      return v;
   endfunction

   vec_t vecs [22];

   // Behavioural reference: a session is either waiting, about to read the ROM,
   // or holding an instruction for execute.
   int         m_phase;      // 0 waiting, 1 reading ROM, 2 holding
   bit         m_single;
   int         m_pc;
   logic [7:0] m_instr;
   bit         m_valid;

   task automatic model_edge;
      case (m_phase)
         0: if (run || step) begin
               m_phase  = 1;
               m_single = !run;
            end
         1: begin
               m_instr = rom_mem[m_pc];
               m_valid = 1;
               m_phase = 2;
            end
         default: if (instr_ready) begin
               m_pc    = jmp_en ? int'(jmp_adrs) : (m_pc + 1) % 16;
               m_valid = 0;
               m_phase = (halt_req || m_single || !run) ? 0 : 1;
            end
      endcase
   endtask

   initial begin
      drive(0, 0, 0, 0, 4'h0, 0);
      load_rom_seq();

      // Reset and idle with run low.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         check_outs("idle", 1'b0, 8'h00, 4'h0, 1'b1);
      end

      // Directed table: stall jump ignored, jump, run drop, single-step,
      // halt during stall, wrap on halt, run beats step, jump to self.
      vecs[0]  = mk(0,0,0,0,4'h0,0, 0,8'h00,4'h0,1);
      vecs[1]  = mk(1,0,0,0,4'h0,0, 0,8'h00,4'h0,0);
      vecs[2]  = mk(1,0,0,0,4'h0,0, 1,8'h10,4'h0,0);
      vecs[3]  = mk(1,1,0,1,4'hC,0, 1,8'h10,4'h0,0);
      vecs[4]  = mk(1,0,1,1,4'hC,0, 0,8'h10,4'hC,0);
      vecs[5]  = mk(1,0,1,0,4'h0,0, 1,8'h1C,4'hC,0);
      vecs[6]  = mk(1,0,1,0,4'h0,0, 0,8'h1C,4'hD,0);
      vecs[7]  = mk(0,0,1,0,4'h0,0, 1,8'h1D,4'hD,0);
      vecs[8]  = mk(0,0,1,0,4'h0,0, 0,8'h1D,4'hE,1);
      vecs[9]  = mk(0,1,0,0,4'h0,0, 0,8'h1D,4'hE,0);
      vecs[10] = mk(0,1,0,0,4'h0,0, 1,8'h1E,4'hE,0);
      vecs[11] = mk(0,1,1,0,4'h0,0, 0,8'h1E,4'hF,1);
      vecs[12] = mk(0,0,0,0,4'h0,0, 0,8'h1E,4'hF,1);
      vecs[13] = mk(1,0,0,0,4'h0,0, 0,8'h1E,4'hF,0);
      vecs[14] = mk(1,0,0,0,4'h0,1, 1,8'h1F,4'hF,0);
      vecs[15] = mk(1,0,0,0,4'h0,1, 1,8'h1F,4'hF,0);
      vecs[16] = mk(1,0,1,0,4'h0,1, 0,8'h1F,4'h0,1);
      vecs[17] = mk(1,1,0,0,4'h0,0, 0,8'h1F,4'h0,0);
      vecs[18] = mk(1,0,1,1,4'h5,0, 1,8'h10,4'h0,0);
      vecs[19] = mk(1,0,1,1,4'h0,0, 0,8'h10,4'h0,0);
      vecs[20] = mk(1,0,1,0,4'h0,0, 1,8'h10,4'h0,0);
      vecs[21] = mk(0,0,1,0,4'h0,0, 0,8'h10,4'h1,1);
      do_reset();
      for (int k = 0; k < 22; k++) begin
         drive(vecs[k].run, vecs[k].step, vecs[k].ready, vecs[k].jmp, vecs[k].jadr, vecs[k].halt);
         tick();
         check_outs($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ei, vecs[k].ep, vecs[k].eh);
      end

      // Free run with instr_ready high: one instruction per two cycles, PC wraps F->0.
      do_reset();
      drive(1, 0, 1, 0, 4'h0, 0);
      for (int e = 1; e <= 34; e++) begin
         tick();
         if (e % 2 == 0) begin
            check_outs($sformatf("wrap%0d", e), 1'b1, 8'h10 + 8'((e/2 - 1) % 16),
                       4'((e/2 - 1) % 16), 1'b0);
         end else begin
            check($sformatf("wrap%0d.valid", e), 32'(instr_valid), 32'd0);
            check($sformatf("wrap%0d.pc", e), 32'(pc), 32'((e - 1) / 2 % 16));
         end
      end

      // Backpressure: instruction held through four stall cycles, PC moves only at handshake.
      rom_mem[0] = 8'h1F;
      do_reset();
      drive(1, 0, 0, 0, 4'h0, 0);
      tick();
      check("bp.fetch_valid", 32'(instr_valid), 32'd0);
      for (int s = 0; s < 4; s++) begin
         tick();
         check_outs($sformatf("bp_stall%0d", s), 1'b1, 8'h1F, 4'h0, 1'b0);
      end
      instr_ready = 1'b1;
      tick();
      check_outs("bp_done", 1'b0, 8'h1F, 4'h1, 1'b0);
      load_rom_seq();

      // Async reset while holding an instruction at pc=1.
      do_reset();
      drive(1, 0, 1, 0, 4'h0, 0);
      repeat (4) tick();
      instr_ready = 1'b0;
      tick();
      check_outs("ar_pre", 1'b1, 8'h11, 4'h1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_outs("ar_now", 1'b0, 8'h00, 4'h0, 1'b1);
      @(negedge clk_cpu);
      reset = 1'b1;

      // Random stimulus against the reference model.
      for (int i = 0; i < 16; i++) rom_mem[i] = 8'($urandom);
      do_reset();
      m_phase = 0; m_single = 0; m_pc = 0; m_instr = 8'h00; m_valid = 0;
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
               4'($urandom), ($urandom_range(0, 9) == 0));
         model_edge();
         tick();
         check_outs($sformatf("rnd%0d", c), m_valid, m_instr, 4'(m_pc), (m_phase == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
